pcie_vc_router: RTL and testbench
=================================

# pcie_vc_router

Parametrised transaction-layer router, successor to the two-VC / two-destination transmit path. It buffers incoming words in a main FIFO and steers them by header bits into NUM_VC virtual-channel FIFOs. A round-robin arbiter with downstream back-pressure drains the VCs into NUM_DEST destination FIFOs. A control FSM latches thresholds at init and reports idle, active and error.

## Interface
Parameters:
- DATA_W, 6: word width, header bits included.
- NUM_VC, 2: virtual channels. Power of two, ≥2. VC_W = clog2(NUM_VC).
- NUM_DEST, 2: destinations. Power of two, ≥2. DEST_W = clog2(NUM_DEST).
- MF_DEPTH, 4: main FIFO depth. Power of two.
- VC_DEPTH, 16: per-VC FIFO depth.
- D_DEPTH, 4: per-destination FIFO depth.

Ports (reset: synchronous, active-high, `reset`; clock: `clk`):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- init  in  1  threshold-load request
- umbral_mf  in  clog2(MF_DEPTH)  main-FIFO almost-full margin
- umbral_vc  in  clog2(VC_DEPTH)  VC almost-full margin
- umbral_d  in  clog2(D_DEPTH)  destination almost-full margin
- push  in  1  write data_in
- data_in  in  DATA_W  word; VC = data_in[DATA_W-1 -: VC_W]; dest = next DEST_W bits below
- pop_d  in  NUM_DEST  per-destination read
- data_out  out  NUM_DEST*DATA_W  head word of each destination, dest k at [k*DATA_W +: DATA_W]
- valid_out  out  NUM_DEST  destination k non-empty
- pause  out  1  main FIFO almost full
- active, idle, error  out  1 each  FSM status
- stat_cnt  out  NUM_DEST*16  delivered-word counters (macro-gated)

## Operation
- FSM states: RESET, INIT, IDLE, ACTIVE, ERROR.
- RESET→INIT on the first cycle after reset deasserts.
- In INIT, while init=1, the three umbral inputs are registered every cycle. When init falls: INIT→IDLE.
- IDLE→ACTIVE when any FIFO is non-empty. ACTIVE→IDLE when all FIFOs are empty.
- Any state except RESET → ERROR on an overflow or underflow event. ERROR is sticky until reset.
- Traffic moves only in IDLE and ACTIVE. Pushes in RESET or INIT are dropped without error.
- Almost-full for each FIFO: count ≥ DEPTH − umbral. pause = main-FIFO almost-full.
- Main FIFO → VC stage: head word moves when VC[head.vc] is not almost-full. At most one word per cycle.
- Arbiter: VC i is eligible when non-empty and dest FIFO[head_i.dest] is not almost-full.
  - One grant per cycle, round-robin starting at rr_ptr.
  - On a grant, rr_ptr ← granted index + 1, mod NUM_VC.
  - With no grant, rr_ptr holds.
- Destination FIFOs are first-word-fall-through. pop_d[k] removes the head on the edge.
- Overflow: push while main FIFO full and not draining that cycle. The word is dropped and error is raised.
- Underflow: pop_d[k] while valid_out[k]=0. Ignored, error raised.
- Push on a full main FIFO in the same cycle it drains one word is accepted.
- All FIFO pointers are log2(DEPTH) bits and wrap naturally. Counts are one bit wider.

## Timing
- Reset values:
  - All FIFOs empty; data_out = 0; valid_out = 0.
  - pause = 0; active = 0; idle = 0; error = 0.
  - rr_ptr = 0; thresholds = 0; stat_cnt = 0; state = RESET.
- idle = 1 only in IDLE. active = 1 only in ACTIVE. error = 1 only in ERROR.
- Latency with no back-pressure: word pushed at edge T is in its VC FIFO after T+1 and in its dest FIFO after T+2. valid_out rises after edge T+2, and the word is poppable at T+3.
- Throughput: one word per cycle through each stage.
- Reset asserted mid-traffic: all contents are discarded on that edge.

## Configuration
- PCIE_VC_STATS_EN defined: stat_cnt[k] increments on each accepted pop_d[k]. It saturates at 16'hFFFF and clears on reset.
- Not defined: stat_cnt is tied to 0 and no counter logic is built.

## Structure
- Package pcie_vc_pkg:
  - FSM state encoding (RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4).
  - clog2 function.
  - Header field-extraction helpers.
  - STAT_W = 16.
- Sub-module pcie_sync_fifo (DATA_W, DEPTH):
  - FWFT, with count, almost-full from an umbral input, and overflow/underflow pulses.
  - Instantiated 1 + NUM_VC + NUM_DEST times.
- The arbiter and FSM live in the top level.

## Test plan
- Reset, then init=1 for 2 cycles with umbral_vc=2 → INIT; after init falls, idle=1 next cycle, all outputs 0.
- Defaults, push 0b010101 (VC0, dest1) at T → valid_out[1]=1 after T+2, data_out[1]=6'h15; pop_d[1] at T+3 → valid_out[1]=0, active→idle.
- Fill VC0 and VC1 each with 4 words targeting dest0, no pops → grants alternate VC0, VC1, VC0, VC1 in order. Pushes stall once dest0 count ≥ 4 − umbral_d.
- Push continuously with dest FIFOs blocked → pause=1 when MF count ≥ MF_DEPTH − umbral_mf. One more push on a full MF → word dropped, error=1, sticky until reset.
- pop_d[0] with valid_out[0]=0 → error=1. Then reset mid-traffic → all valid_out=0, state RESET.
- With PCIE_VC_STATS_EN, 5 pops on dest1 → stat_cnt[1]=5. Without the macro, stat_cnt=0.

Source files
------------

// File: rtl/pcie_vc_pkg.sv
// Shared definitions for the pcie_vc_router slice: FSM encoding, clog2,
// header field helpers and the statistics counter width.
package pcie_vc_pkg;

  localparam int STAT_W = 16;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // VC field: the top vc_w bits of the word.
  function automatic int unsigned hdr_vc(input logic [63:0] word, input int data_w,
                                         input int vc_w);
    return int'((word >> (data_w - vc_w)) & ((64'd1 << vc_w) - 64'd1));
  endfunction

  // Destination field: the dest_w bits just below the VC field.
  function automatic int unsigned hdr_dest(input logic [63:0] word, input int data_w,
                                           input int vc_w, input int dest_w);
    return int'((word >> (data_w - vc_w - dest_w)) & ((64'd1 << dest_w) - 64'd1));
  endfunction

endpackage

// File: rtl/pcie_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count, a
// programmable almost-full margin and overflow/underflow event pulses.
// A push on a full FIFO is accepted when the same cycle pops a word.
module pcie_sync_fifo
  import pcie_vc_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic [AW-1:0]     umbral,
  output logic [DATA_W-1:0] data_out,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty       = (count_reg == '0);
  assign full        = (count_reg == (AW+1)'(DEPTH));
  assign do_pop      = pop && !empty;
  assign do_push     = push && (!full || do_pop);
  assign overflow    = push && full && !do_pop;
  assign underflow   = pop && empty;
  assign almost_full = (count_reg >= ((AW+1)'(DEPTH) - {1'b0, umbral}));
  assign count       = count_reg;
  // Head word is visible while non-empty; an empty FIFO presents zero.
  assign data_out    = empty ? '0 : mem[rd_ptr_reg];

  // Storage array; not reset so it maps onto RAM resources.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= data_in;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/pcie_vc_router.sv
// Transaction-layer router: main FIFO -> NUM_VC virtual-channel FIFOs ->
// round-robin arbiter -> NUM_DEST destination FIFOs, plus control FSM.
// Optional feature: define PCIE_VC_STATS_EN to build per-destination
// delivered-word counters on stat_cnt; otherwise stat_cnt is tied to 0.
module pcie_vc_router
  import pcie_vc_pkg::*;
#(
  parameter int DATA_W   = 6,
  parameter int NUM_VC   = 2,
  parameter int NUM_DEST = 2,
  parameter int MF_DEPTH = 4,
  parameter int VC_DEPTH = 16,
  parameter int D_DEPTH  = 4,
  localparam int VC_W    = clog2(NUM_VC),
  localparam int DEST_W  = clog2(NUM_DEST),
  localparam int MF_AW   = clog2(MF_DEPTH),
  localparam int VC_AW   = clog2(VC_DEPTH),
  localparam int D_AW    = clog2(D_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [MF_AW-1:0]           umbral_mf,
  input  logic [VC_AW-1:0]           umbral_vc,
  input  logic [D_AW-1:0]            umbral_d,
  input  logic                       push,
  input  logic [DATA_W-1:0]          data_in,
  input  logic [NUM_DEST-1:0]        pop_d,
  output logic [NUM_DEST*DATA_W-1:0] data_out,
  output logic [NUM_DEST-1:0]        valid_out,
  output logic                       pause,
  output logic                       active,
  output logic                       idle,
  output logic                       error,
  output logic [NUM_DEST*STAT_W-1:0] stat_cnt
);

  state_t            state_reg;
  logic              idle_reg, active_reg, error_reg;
  logic [MF_AW-1:0]  umbral_mf_reg;
  logic [VC_AW-1:0]  umbral_vc_reg;
  logic [D_AW-1:0]   umbral_d_reg;
  logic [VC_W-1:0]   rr_ptr_reg;

  logic              traffic_en;
  logic              mf_empty, mf_afull, mf_overflow, mf_move;
  logic [DATA_W-1:0] mf_head;
  logic [VC_W-1:0]   mf_vc;
  logic [NUM_VC-1:0] vc_empty, vc_afull, vc_elig, vc_grant;
  logic [DATA_W-1:0] vc_head [NUM_VC];
  logic [DEST_W-1:0] vc_dest [NUM_VC];
  logic              grant_valid;
  logic [VC_W-1:0]   grant_idx, scan_idx;
  logic [NUM_DEST-1:0] d_empty, d_afull, d_underflow;
  logic              any_nonempty, err_event;

  logic              mf_underflow_unused;
  logic [MF_AW:0]    mf_count_unused;
  logic [VC_AW:0]    vc_count_unused [NUM_VC];
  logic [NUM_VC-1:0] vc_ovf_unused, vc_unf_unused;
  logic [D_AW:0]     d_count_unused [NUM_DEST];
  logic [NUM_DEST-1:0] d_ovf_unused;

  assign traffic_en = (state_reg == ST_IDLE) || (state_reg == ST_ACTIVE);
  assign mf_vc      = VC_W'(hdr_vc(64'(mf_head), DATA_W, VC_W));
  assign mf_move    = traffic_en && !mf_empty && !vc_afull[mf_vc];

  pcie_sync_fifo #(.DATA_W(DATA_W), .DEPTH(MF_DEPTH)) u_main_fifo (
    .clk, .reset,
    .push(push && traffic_en), .pop(mf_move), .data_in(data_in),
    .umbral(umbral_mf_reg), .data_out(mf_head), .count(mf_count_unused),
    .empty(mf_empty), .almost_full(mf_afull),
    .overflow(mf_overflow), .underflow(mf_underflow_unused)
  );

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
    pcie_sync_fifo #(.DATA_W(DATA_W), .DEPTH(VC_DEPTH)) u_vc_fifo (
      .clk, .reset,
      .push(mf_move && (mf_vc == VC_W'(gi))), .pop(vc_grant[gi]), .data_in(mf_head),
      .umbral(umbral_vc_reg), .data_out(vc_head[gi]), .count(vc_count_unused[gi]),
      .empty(vc_empty[gi]), .almost_full(vc_afull[gi]),
      .overflow(vc_ovf_unused[gi]), .underflow(vc_unf_unused[gi])
    );
    assign vc_dest[gi] = DEST_W'(hdr_dest(64'(vc_head[gi]), DATA_W, VC_W, DEST_W));
    assign vc_elig[gi] = traffic_en && !vc_empty[gi] && !d_afull[vc_dest[gi]];
  end

  // Round-robin pick: scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int off = NUM_VC - 1; off >= 0; off--) begin
      scan_idx = rr_ptr_reg + VC_W'(off);
      if (vc_elig[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign vc_grant = grant_valid ? (NUM_VC'(1) << grant_idx) : '0;

  for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_dest
    pcie_sync_fifo #(.DATA_W(DATA_W), .DEPTH(D_DEPTH)) u_d_fifo (
      .clk, .reset,
      .push(grant_valid && (vc_dest[grant_idx] == DEST_W'(gi))),
      .pop(pop_d[gi] && traffic_en), .data_in(vc_head[grant_idx]),
      .umbral(umbral_d_reg), .data_out(data_out[gi*DATA_W +: DATA_W]),
      .count(d_count_unused[gi]), .empty(d_empty[gi]), .almost_full(d_afull[gi]),
      .overflow(d_ovf_unused[gi]), .underflow(d_underflow[gi])
    );
    assign valid_out[gi] = !d_empty[gi];
  end

  assign pause        = mf_afull;
  assign any_nonempty = !mf_empty || !(&vc_empty) || !(&d_empty);
  assign err_event    = mf_overflow || (|d_underflow);

  // Arbiter pointer advances past the granted VC, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset)            rr_ptr_reg <= '0;
    else if (grant_valid) rr_ptr_reg <= grant_idx + VC_W'(1);
  end

  // Control FSM with registered status flags and threshold capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_RESET;
      idle_reg      <= 1'b0;
      active_reg    <= 1'b0;
      error_reg     <= 1'b0;
      umbral_mf_reg <= '0;
      umbral_vc_reg <= '0;
      umbral_d_reg  <= '0;
    end else begin
      case (state_reg)
        ST_RESET: state_reg <= ST_INIT;
        ST_INIT: begin
          if (init) begin
            umbral_mf_reg <= umbral_mf;
            umbral_vc_reg <= umbral_vc;
            umbral_d_reg  <= umbral_d;
          end else begin
            state_reg <= ST_IDLE;
            idle_reg  <= 1'b1;
          end
        end
        ST_IDLE, ST_ACTIVE: begin
          if (err_event) begin
            state_reg  <= ST_ERROR;
            idle_reg   <= 1'b0;
            active_reg <= 1'b0;
            error_reg  <= 1'b1;
          end else if (any_nonempty) begin
            state_reg  <= ST_ACTIVE;
            idle_reg   <= 1'b0;
            active_reg <= 1'b1;
          end else begin
            state_reg  <= ST_IDLE;
            idle_reg   <= 1'b1;
            active_reg <= 1'b0;
          end
        end
        ST_ERROR: state_reg <= ST_ERROR;
        default: begin
          state_reg  <= ST_RESET;
          idle_reg   <= 1'b0;
          active_reg <= 1'b0;
          error_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign idle   = idle_reg;
  assign active = active_reg;
  assign error  = error_reg;

`ifdef PCIE_VC_STATS_EN
  for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_stat
    logic [STAT_W-1:0] cnt_reg;
    // Count accepted pops, saturating at all-ones.
    always_ff @(posedge clk) begin
      if (reset) cnt_reg <= '0;
      else if (pop_d[gi] && traffic_en && !d_empty[gi] && (cnt_reg != '1))
        cnt_reg <= cnt_reg + STAT_W'(1);
    end
    assign stat_cnt[gi*STAT_W +: STAT_W] = cnt_reg;
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_pcie_vc_router.sv
// Randomized self-checking bench for pcie_vc_router against a queue-level
// reference model built from the routing rules.
module tb_pcie_vc_router;
  import pcie_vc_pkg::*;

  localparam int DATA_W = 6, NUM_VC = 2, NUM_DEST = 2;
  localparam int MF_DEPTH = 4, VC_DEPTH = 16, D_DEPTH = 4;
  localparam int VC_W = 1, DEST_W = 1;
  localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       reset = 1'b1, init = 1'b0, push = 1'b0;
  logic [1:0]                 umbral_mf = '0, umbral_d = '0;
  logic [3:0]                 umbral_vc = '0;
  logic [DATA_W-1:0]          data_in = '0;
  logic [NUM_DEST-1:0]        pop_d = '0;
  logic [NUM_DEST*DATA_W-1:0] data_out;
  logic [NUM_DEST-1:0]        valid_out;
  logic                       pause, active, idle, error;
  logic [NUM_DEST*STAT_W-1:0] stat_cnt;

  pcie_vc_router dut (
    .clk(clk), .reset(reset), .init(init), .umbral_mf(umbral_mf),
    .umbral_vc(umbral_vc), .umbral_d(umbral_d), .push(push), .data_in(data_in),
    .pop_d(pop_d), .data_out(data_out), .valid_out(valid_out), .pause(pause),
    .active(active), .idle(idle), .error(error), .stat_cnt(stat_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mfq[$];
  logic [DATA_W-1:0] vcq[NUM_VC][$];
  logic [DATA_W-1:0] dq[NUM_DEST][$];
  int m_state = M_RESET, m_rr = 0, m_u_mf = 0, m_u_vc = 0, m_u_d = 0;
  int m_stat[NUM_DEST];

  function automatic int f_vc(input logic [DATA_W-1:0] w);
    return (int'(w) >> (DATA_W - VC_W)) % NUM_VC;
  endfunction
  function automatic int f_dest(input logic [DATA_W-1:0] w);
    return (int'(w) >> (DATA_W - VC_W - DEST_W)) % NUM_DEST;
  endfunction

  task automatic model_clear();
    mfq.delete();
    for (int v = 0; v < NUM_VC; v++) vcq[v].delete();
    for (int k = 0; k < NUM_DEST; k++) begin dq[k].delete(); m_stat[k] = 0; end
    m_state = M_RESET; m_rr = 0; m_u_mf = 0; m_u_vc = 0; m_u_d = 0;
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_step();
    bit en, empty_all, err, mv;
    int mv_vc, g, idx;
    if (reset) begin model_clear(); return; end
    en = (m_state == M_IDLE) || (m_state == M_ACTIVE);
    empty_all = (mfq.size() == 0);
    for (int v = 0; v < NUM_VC; v++) if (vcq[v].size() != 0) empty_all = 0;
    for (int k = 0; k < NUM_DEST; k++) if (dq[k].size() != 0) empty_all = 0;
    err = 0; mv = 0; mv_vc = 0; g = -1;
    if (en) begin
      if (mfq.size() > 0) begin
        mv_vc = f_vc(mfq[0]);
        mv = vcq[mv_vc].size() < VC_DEPTH - m_u_vc;
      end
      for (int off = 0; off < NUM_VC; off++) begin
        idx = (m_rr + off) % NUM_VC;
        if (g < 0 && vcq[idx].size() > 0)
          if (dq[f_dest(vcq[idx][0])].size() < D_DEPTH - m_u_d) g = idx;
      end
      for (int k = 0; k < NUM_DEST; k++) if (pop_d[k]) begin
        if (dq[k].size() > 0) begin
          $display("pop  dest%0d word %02h", k, dq[k][0]);
          void'(dq[k].pop_front());
          if (m_stat[k] < 65535) m_stat[k]++;
        end else err = 1;
      end
      if (g >= 0) begin
        dq[f_dest(vcq[g][0])].push_back(vcq[g].pop_front());
        m_rr = (g + 1) % NUM_VC;
      end
      if (mv) vcq[mv_vc].push_back(mfq.pop_front());
      if (push) begin
        if (mfq.size() < MF_DEPTH) mfq.push_back(data_in);
        else err = 1;
      end
    end
    case (m_state)
      M_RESET: m_state = M_INIT;
      M_INIT: if (init) begin
                m_u_mf = int'(umbral_mf); m_u_vc = int'(umbral_vc); m_u_d = int'(umbral_d);
              end else m_state = M_IDLE;
      M_IDLE, M_ACTIVE: m_state = err ? M_ERROR : (empty_all ? M_IDLE : M_ACTIVE);
      default: m_state = M_ERROR;
    endcase
  endtask

  task automatic compare_all();
    logic [DATA_W-1:0] exp_w;
    for (int k = 0; k < NUM_DEST; k++) begin
      exp_w = (dq[k].size() > 0) ? dq[k][0] : '0;
      check_eq($sformatf("valid_out%0d", k), 32'(valid_out[k]), 32'(dq[k].size() > 0));
      check_eq($sformatf("data_out%0d", k), 32'(data_out[k*DATA_W +: DATA_W]), 32'(exp_w));
`ifdef PCIE_VC_STATS_EN
      check_eq($sformatf("stat_cnt%0d", k), 32'(stat_cnt[k*STAT_W +: STAT_W]), 32'(m_stat[k]));
`else
      check_eq($sformatf("stat_cnt%0d", k), 32'(stat_cnt[k*STAT_W +: STAT_W]), 32'd0);
`endif
    end
    check_eq("pause", 32'(pause), 32'(mfq.size() >= MF_DEPTH - m_u_mf));
    check_eq("idle", 32'(idle), 32'(m_state == M_IDLE));
    check_eq("active", 32'(active), 32'(m_state == M_ACTIVE));
    check_eq("error", 32'(error), 32'(m_state == M_ERROR));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle(input bit p, input logic [DATA_W-1:0] d,
                       input logic [NUM_DEST-1:0] pd, input bit i, input bit r);
    @(negedge clk);
    reset = r; init = i; push = p; data_in = d; pop_d = pd;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) cycle(0, '0, '0, 0, 0);
  endtask

  task automatic start(input int umf, input int uvc, input int ud);
    for (int c = 0; c < 3; c++) cycle(0, '0, '0, 0, 1);
    umbral_mf = 2'(umf); umbral_vc = 4'(uvc); umbral_d = 2'(ud);
    for (int c = 0; c < 3; c++) cycle(0, '0, '0, 1, 0);
    cycle(0, '0, '0, 0, 0);
  endtask

  // Pop every destination whenever it holds data, for n cycles.
  task automatic drain(input int n);
    logic [NUM_DEST-1:0] pd;
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < NUM_DEST; k++) pd[k] = dq[k].size() > 0;
      cycle(0, '0, pd, 0, 0);
    end
  endtask

  initial begin
    model_clear();

    // Init sequence and single-word latency.
    start(0, 2, 0);
    check_eq("init_idle", 32'(idle), 32'd1);
    cycle(1, 6'b010101, '0, 0, 0);
    idle_cycles(2);
    check_eq("lat_valid1", 32'(valid_out[1]), 32'd1);
    check_eq("lat_data1", 32'(data_out[DATA_W +: DATA_W]), 32'h15);
    cycle(0, '0, 2'b10, 0, 0);
    check_eq("pop_valid1", 32'(valid_out[1]), 32'd0);
    idle_cycles(2);
    check_eq("back_idle", 32'(idle), 32'd1);

    // Round-robin: four words each on VC0 and VC1, all to dest0.
    start(0, 2, 0);
    for (int j = 0; j < 4; j++) begin
      cycle(1, DATA_W'(6'b000000 | j), '0, 0, 0);
      cycle(1, DATA_W'(6'b100000 | j), '0, 0, 0);
    end
    idle_cycles(8);
    drain(16);

    // Back-pressure, pause and overflow with destinations blocked.
    start(1, 2, 0);
    for (int j = 0; j < 30; j++) cycle(1, DATA_W'(j % 16), '0, 0, 0);
    check_eq("ovf_error", 32'(error), 32'd1);
    idle_cycles(3);
    check_eq("err_sticky", 32'(error), 32'd1);

    // Underflow, then reset while words are still buffered.
    start(0, 0, 0);
    cycle(1, 6'b010001, '0, 0, 0);
    cycle(1, 6'b110010, '0, 0, 0);
    idle_cycles(3);
    cycle(0, '0, 2'b01, 0, 0);
    check_eq("unf_error", 32'(error), 32'd1);
    cycle(0, '0, '0, 0, 1);
    check_eq("rst_valid", 32'(valid_out), 32'd0);

    // Five deliveries on dest1 for the statistics counter.
    start(0, 0, 0);
    for (int j = 0; j < 5; j++) cycle(1, DATA_W'(6'b010000 | j), '0, 0, 0);
    drain(12);
`ifdef PCIE_VC_STATS_EN
    check_eq("stat1_five", 32'(stat_cnt[STAT_W +: STAT_W]), 32'd5);
`else
    check_eq("stat1_zero", 32'(stat_cnt[STAT_W +: STAT_W]), 32'd0);
`endif

    // Randomized traffic with random thresholds; reset mid-traffic at the end.
    start($urandom_range(0, MF_DEPTH - 1), $urandom_range(0, VC_DEPTH - 1),
          $urandom_range(0, D_DEPTH - 1));
    for (int c = 0; c < 400; c++) begin
      bit p;
      logic [NUM_DEST-1:0] pd;
      p = ($urandom_range(0, 3) != 0) && (mfq.size() < MF_DEPTH);
      for (int k = 0; k < NUM_DEST; k++)
        pd[k] = (dq[k].size() > 0) && ($urandom_range(0, 2) == 0);
      cycle(p, DATA_W'($urandom), pd, 0, 0);
    end
    cycle(0, '0, '0, 0, 1);
    check_eq("rst_idle", 32'(idle), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
